// File: rtl/keypad_scan_ctrl.sv
// 4x4 hex keypad row scanner with synchronizer, press/release debounce
// and a one-cycle key_valid strobe per accepted key.
//
// Ports:
//   clk       - system clock, rising edge
//   reset     - asynchronous active-low reset
//   col[3:0]  - raw column sense, active-high, asynchronous (col[0] = left)
//   row[3:0]  - one-hot active-high row drive (row[0] = top)
//   key[3:0]  - hex code of last accepted key, held until next accept
//   key_valid - one-cycle pulse when key is updated
//   key_held  - high while the accepted key is still pressed
module keypad_scan_ctrl #(
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    localparam int MAXC  = (SCAN_DWELL > DEBOUNCE_CYCLES) ?
                           SCAN_DWELL : DEBOUNCE_CYCLES,
    localparam int CNT_W = $clog2(MAXC) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        REPORT   = 2'd2,
        HOLD     = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DWELL - 1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       row_n;
    logic [3:0]       key_n;
    logic [3:0]       col_lat, col_lat_n;
    logic [3:0]       col_m, col_s;
    logic             one_hot;
    logic [3:0]       row_rot;

    function automatic logic [3:0] keymap(input logic [3:0] r,
                                          input logic [3:0] c);
        logic [1:0] ri;
        logic [1:0] ci;
        logic [3:0] code;
        ri = 2'd0;
        ci = 2'd0;
        unique case (1'b1)
            r[1]:    ri = 2'd1;
            r[2]:    ri = 2'd2;
            r[3]:    ri = 2'd3;
            default: ri = 2'd0;
        endcase
        unique case (1'b1)
            c[1]:    ci = 2'd1;
            c[2]:    ci = 2'd2;
            c[3]:    ci = 2'd3;
            default: ci = 2'd0;
        endcase
        case ({ri, ci})
            4'h0:    code = 4'h1;
            4'h1:    code = 4'h2;
            4'h2:    code = 4'h3;
            4'h3:    code = 4'hA;
            4'h4:    code = 4'h4;
            4'h5:    code = 4'h5;
            4'h6:    code = 4'h6;
            4'h7:    code = 4'hB;
            4'h8:    code = 4'h7;
            4'h9:    code = 4'h8;
            4'hA:    code = 4'h9;
            4'hB:    code = 4'hC;
            4'hC:    code = 4'hE;
            4'hD:    code = 4'h0;
            4'hE:    code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // two-flop synchronizer; col_s is the only column view used below
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_m <= '0;
            col_s <= '0;
        end else begin
            col_m <= col;
            col_s <= col_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            cnt     <= '0;
            row     <= 4'b0001;
            key     <= 4'h0;
            col_lat <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            row     <= row_n;
            key     <= key_n;
            col_lat <= col_lat_n;
        end
    end

    // exactly one column set; zero or multiple columns is "no press"
    assign one_hot = (col_s != 4'b0000) &&
                     ((col_s & (col_s - 4'd1)) == 4'b0000);
    assign row_rot = {row[2:0], row[3]};

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        row_n     = row;
        key_n     = key;
        col_lat_n = col_lat;
        case (state)
            SCAN: begin
                if (cnt == DWELL_LAST) begin
                    cnt_n = '0;
                    if (one_hot) begin
                        col_lat_n = col_s;
                        state_n   = DEBOUNCE;
                    end else begin
                        row_n = row_rot;
                    end
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            DEBOUNCE: begin
                if (col_s != col_lat) begin
                    cnt_n   = '0;
                    row_n   = row_rot;
                    state_n = SCAN;
                end else if (cnt == DEB_LAST) begin
                    cnt_n   = '0;
                    key_n   = keymap(row, col_lat);
                    state_n = REPORT;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            REPORT: begin
                cnt_n   = '0;
                state_n = HOLD;
            end
            HOLD: begin
                // other rows are not driven, so only this key's release counts
                if (col_s != 4'b0000) begin
                    cnt_n = '0;
                end else if (cnt == DEB_LAST) begin
                    cnt_n   = '0;
                    row_n   = row_rot;
                    state_n = SCAN;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                cnt_n   = '0;
                row_n   = 4'b0001;
                state_n = SCAN;
            end
        endcase
    end

    assign key_valid = (state == REPORT);
    assign key_held  = (state == HOLD);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad matrix model, expected-key queue
// filled by stimulus, popped by a monitor on every key_valid.
module tb_keypad_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed;
    int          checks = 0;
    int          fails  = 0;
    int          exp_q[$];

    // key index = row*4 + column
    localparam logic [3:0] KMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    always #5 clk = ~clk;

    keypad_scan_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // switch matrix: a pressed key shorts its row line to its column line
    always_comb begin
        col = 4'b0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && row[r]) col[c] = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_row(input logic [3:0] t);
        int n = 0;
        while (row !== t && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_row", 32'(row), 32'(t));
    endtask

    task automatic press_clean(input int k, input int hold);
        exp_q.push_back(k);
        pressed[k] = 1'b1;
        cyc(hold);
        pressed[k] = 1'b0;
        cyc(25);
    endtask

    always @(negedge clk) begin
        if (reset && key_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL spurious_valid: key=%0h, no report expected",
                         key);
            end else begin
                int idx;
                idx = exp_q.pop_front();
                check("key_code", 32'(key), 32'(KMAP[idx]));
                check("row_at_valid", 32'(row), 32'(4'b0001 << (idx / 4)));
                check("held_at_valid", 32'(key_held), 32'd0);
            end
        end
    end

    initial begin
        reset   = 1'b0;
        pressed = '0;
        cyc(3);
        check("rst_row", 32'(row), 32'h1);
        check("rst_key", 32'(key), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);

        // idle scan: each row held four cycles
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("row_seq", 32'(row), 32'(4'b0001 << ((i / 4) % 4)));
            @(negedge clk);
        end

        // key 6 held: row freezes, release needs 8 quiet synced cycles
        exp_q.push_back(6);
        pressed[6] = 1'b1;
        cyc(40);
        check("frozen_row", 32'(row), 32'h2);
        check("held_on", 32'(key_held), 32'h1);
        check("key6_hold", 32'(key), 32'h6);
        pressed[6] = 1'b0;
        cyc(9);
        check("held_before_rel", 32'(key_held), 32'h1);
        cyc(3);
        check("held_after_rel", 32'(key_held), 32'h0);
        check("row_after_rel", 32'(row), 32'h4);
        check("key_kept", 32'(key), 32'h6);
        cyc(20);

        // bounce on key 1: short burst, gap, then stable
        exp_q.push_back(0);
        pressed[0] = 1'b1;
        cyc(5);
        pressed[0] = 1'b0;
        cyc(1);
        pressed[0] = 1'b1;
        cyc(40);
        pressed[0] = 1'b0;
        cyc(25);

        // two columns in one row is no press
        pressed = 16'h0003;
        cyc(40);
        check("dual_no_hold", 32'(key_held), 32'h0);
        pressed = '0;
        cyc(10);

        for (int k = 0; k < 16; k++) press_clean(k, 40);

        // D held, then 5 pressed during HOLD; 5 reported after D release
        exp_q.push_back(15);
        exp_q.push_back(5);
        pressed[15] = 1'b1;
        cyc(40);
        pressed[5] = 1'b1;
        cyc(20);
        check("hold_d_held", 32'(key_held), 32'h1);
        check("hold_d_key", 32'(key), 32'hD);
        pressed[15] = 1'b0;
        cyc(45);
        pressed[5] = 1'b0;
        cyc(25);

        // reset in mid-debounce on key 9 discards the press
        wait_row(4'b0010);
        pressed[10] = 1'b1;
        wait_row(4'b0100);
        cyc(8);
        check("deb_row_frozen", 32'(row), 32'h4);
        check("deb_no_valid", 32'(key_valid), 32'h0);
        reset = 1'b0;
        #1;
        check("mid_rst_row", 32'(row), 32'h1);
        check("mid_rst_key", 32'(key), 32'h0);
        check("mid_rst_valid", 32'(key_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(10);
        cyc(40);
        pressed[10] = 1'b0;
        cyc(25);

        // random episodes: clean, bounce, glitch, dual-key
        for (int e = 0; e < 14; e++) begin
            int k;
            int mode;
            k    = $urandom_range(0, 15);
            mode = $urandom_range(0, 3);
            case (mode)
                0: press_clean(k, $urandom_range(40, 60));
                1: begin
                    exp_q.push_back(k);
                    pressed[k] = 1'b1;
                    cyc($urandom_range(2, 5));
                    pressed[k] = 1'b0;
                    cyc(1);
                    pressed[k] = 1'b1;
                    cyc(45);
                    pressed[k] = 1'b0;
                    cyc(25);
                end
                2: begin
                    pressed[k] = 1'b1;
                    cyc($urandom_range(1, 4));
                    pressed[k] = 1'b0;
                    cyc(20);
                end
                default: begin
                    int r;
                    int c2;
                    r  = k / 4;
                    c2 = ((k % 4) + $urandom_range(1, 3)) % 4;
                    pressed[k]      = 1'b1;
                    pressed[r*4+c2] = 1'b1;
                    cyc(40);
                    pressed = '0;
                    cyc(20);
                end
            endcase
        end

        cyc(30);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
